dac_out_stage: RTL
==================

// Module: dac_out_stage
// PURPOSE
//  Final stage after the FM/AM modulator data-path. Takes the 14-bit signed o_data/val_out stream.
//  Buffers it in a small FIFO and paces samples to the DAC at a programmable update rate.
//  Converts each sample to the DAC's code format. Flags overflow and underflow.
//  Holds the last code on underflow and re-primes the FIFO before resuming.
// PARAMETERS
//  W        14  sample width (signed in, DAC code out)
//  DEPTH    8   FIFO depth in samples; power of 2, >= 4
//  FILL_LVL 4   FIFO level required to leave FILL; 1..DEPTH
//  DIV_W    8   width of dac_div
// PORTS
//  clk        in   1      system clock, all logic rising-edge
//  rst        in   1      synchronous, active-high reset
//  i_data     in   W      signed sample from modulator
//  val_in     in   1      i_data valid, one-cycle qualifier
//  dac_div    in   DIV_W  DAC update period = dac_div+1 clk cycles; sampled at each strobe
//  fmt_twos   in   1      1: two's complement code out; 0: offset binary
//  o_dac      out  W      DAC code, registered
//  dac_wr     out  1      one-cycle pulse when o_dac takes a new code
//  ovf        out  1      one-cycle pulse: sample dropped because FIFO full
//  unf        out  1      one-cycle pulse: strobe found FIFO empty in RUN
//  level      out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset outputs:
//   - o_dac = midscale: 14'h2000 if fmt_twos=0, 0 if fmt_twos=1 (evaluated during rst).
//   - dac_wr = ovf = unf = 0; level = 0.
//   - FIFO pointers and divider counter cleared; state = FILL.
//  Rate counter:
//   - cnt counts 0..dac_div.
//   - strobe is asserted when cnt==dac_div, then cnt reloads to 0.
//   - With dac_div=0, strobe fires every cycle.
//   - Runs in all states.
//  Write side:
//   - val_in && !full -> push i_data.
//   - val_in && full && !pop -> drop the sample and pulse ovf in the same cycle.
//   - If val_in, full and pop coincide, the write is accepted and level is unchanged.
//  Read-after-write: a sample pushed in cycle t is poppable no earlier than cycle t+1 (no fall-through).
//  FSM (2 states):
//   - FILL: no pops; o_dac holds. Go to RUN when level >= FILL_LVL at a strobe.
//     That strobe performs the first pop.
//   - RUN: each strobe with !empty pops one sample.
//     Each strobe with empty pulses unf, holds o_dac, does not pulse dac_wr, and goes to FILL.
//  Output latency: in a pop at strobe cycle s, o_dac and dac_wr=1 are updated at s+1.
//   dac_wr is high for exactly 1 cycle.
//  Format conversion (at pop):
//   - offset binary: {~d[W-1], d[W-2:0]}
//   - two's complement: d unchanged
//   - A fmt_twos change applies from the next pop; the held code is not rewritten.
//  Reset mid-operation: FIFO content is discarded. No ovf/unf/dac_wr pulse is generated by the reset.
// CONFIGURATION
//  Macro DAC_OUT_STATS_EN.
//  Defined:
//   - Adds outputs ovf_cnt[15:0] and unf_cnt[15:0], saturating at 16'hFFFF.
//   - Each counter increments on its pulse and is cleared by rst.
//   - Adds input stats_clr (1 cycle). Clearing and incrementing in the same cycle gives a result of 1.
//  Undefined: the ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Package dac_out_pkg:
//   - state enum {ST_FILL, ST_RUN}
//   - MIDSCALE_OB = 14'h2000
//   - function to_dac_code(d, fmt_twos)
//  Sub-module dac_fifo (DEPTH x W synchronous FIFO):
//   - push/pop/full/empty/level
//   - extra pointer bit for full/empty
//  Top module: rate counter, FSM, format/output register, and stats.
// TESTING
//  1. rst held 3 cycles, fmt_twos=0 -> o_dac=14'h2000, dac_wr/ovf/unf=0, level=0.
//  2. dac_div=3, write 4 samples back-to-back, FILL_LVL=4 -> first dac_wr occurs 1 cycle after
//     the next strobe. Codes are spaced 4 cycles apart. Sample -8192 -> o_dac=14'h0000, 8191 -> 14'h3FFF.
//  3. fmt_twos=1, sample -1 -> o_dac=14'h3FFF; fmt_twos=0, sample -1 -> o_dac=14'h1FFF.
//  4. dac_div=7, val_in every cycle for 20 cycles -> level reaches 8, then ovf pulses every
//     non-pop cycle. No pulse occurs on a pop cycle. Accepted order is preserved at o_dac.
//  5. dac_div=0 with sparse input (every 10 cycles) -> unf pulses, o_dac holds its last code,
//     FSM returns to FILL and resumes only after 4 samples are buffered.
//  6. Assert rst with level=5 in RUN -> next cycle level=0, o_dac=midscale, and no dac_wr occurs
//     until the FIFO is refilled. With DAC_OUT_STATS_EN, counters read 0.

Source files
------------

// File: rtl/dac_out_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dac_out_pkg
//  Brief    : Shared types, constants and code conversion for dac_out_stage.
//  Revision : 1.0 - initial release
// ============================================================================
package dac_out_pkg;

  // Two-state output pacing FSM.
  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Native DAC code width the helper below is written for.
  localparam int DAC_W = 14;

  // Offset-binary midscale: the code that represents 0 V.
  localparam logic [DAC_W-1:0] MIDSCALE_OB = 14'h2000;

  // Signed sample -> DAC code. Offset binary is just the sign bit flipped.
  function automatic logic [DAC_W-1:0] to_dac_code(input logic [DAC_W-1:0] d,
                                                    input logic             fmt_twos);
    if (fmt_twos) begin
      to_dac_code = d;
    end else begin
      to_dac_code = {~d[DAC_W-1], d[DAC_W-2:0]};
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/dac_out_stage_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : dac_fifo
//  Brief    : DEPTH x W synchronous FIFO, registered storage, no fall-through.
//             Pointers carry one extra wrap bit to tell full from empty.
//  Revision : 1.0 - initial release
// ============================================================================
module dac_fifo #(
  parameter int W     = 14,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wr_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         w_do_push;
  logic         w_do_pop;

  // Status flags, read port and pointer advance; a push into a full FIFO is
  // only legal when the same cycle frees a slot.
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    level     = wr_ptr_q - rd_ptr_q;
    rd_data   = mem_q[rd_ptr_q[AW-1:0]];
    w_do_pop  = pop && !empty;
    w_do_push = push && (!full || w_do_pop);
    wr_ptr_d  = w_do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = w_do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  // Pointer registers; reset discards any buffered content.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dac_out_stage.sv
`default_nettype none
// ============================================================================
//  Module   : dac_out_stage
//  Brief    : Buffers modulator samples, paces them to the DAC at
//             (dac_div+1) clocks per update, converts to the DAC code format
//             and flags overflow / underflow. On underflow the last code is
//             held and the FIFO is re-primed to FILL_LVL before resuming.
//  Options  : DAC_OUT_STATS_EN adds saturating ovf/unf event counters.
//  Revision : 1.0 - initial release
// ============================================================================
module dac_out_stage
  import dac_out_pkg::*;
#(
  parameter int W        = 14,
  parameter int DEPTH    = 8,
  parameter int FILL_LVL = 4,
  parameter int DIV_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             i_data,
  input  logic                     val_in,
  input  logic [DIV_W-1:0]         dac_div,
  input  logic                     fmt_twos,
`ifdef DAC_OUT_STATS_EN
  input  logic                     stats_clr,
  output logic [15:0]              ovf_cnt,
  output logic [15:0]              unf_cnt,
`endif
  output logic [W-1:0]             o_dac,
  output logic                     dac_wr,
  output logic                     ovf,
  output logic                     unf,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int LW = $clog2(DEPTH) + 1;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     o_dac_q, o_dac_d;
  logic             dac_wr_q, dac_wr_d;

  logic             w_strobe;
  logic             w_pop;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic             w_fill_ok;
  logic [W-1:0]     w_rd_data;
  logic [W-1:0]     w_code;
  logic [W-1:0]     w_midscale;
  logic [LW-1:0]    w_level;

  dac_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .wr_data (i_data),
    .pop     (w_pop),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty),
    .level   (w_level)
  );

  // Code conversion: the package helper covers the native 14-bit DAC; other
  // widths use the same sign-flip rule written generically.
  generate
    if (W == DAC_W) begin : g_pkg_conv
      always_comb begin
        w_code     = to_dac_code(w_rd_data, fmt_twos);
        w_midscale = MIDSCALE_OB;
      end
    end else begin : g_generic_conv
      always_comb begin
        w_code     = fmt_twos ? w_rd_data : {~w_rd_data[W-1], w_rd_data[W-2:0]};
        w_midscale = {1'b1, {(W-1){1'b0}}};
      end
    end
  endgenerate

  // Rate counter: free-running 0..dac_div; ">=" keeps it from running the
  // long way round if dac_div is lowered below the current count.
  always_comb begin
    w_strobe = (cnt_q >= dac_div);
    cnt_d    = w_strobe ? '0 : cnt_q + DIV_W'(1);
  end

  // FSM next-state, pop decision and event pulses (ovf/unf are same-cycle).
  always_comb begin
    state_d   = state_q;
    w_pop     = 1'b0;
    unf       = 1'b0;
    w_fill_ok = (w_level >= LW'(FILL_LVL));
    case (state_q)
      ST_FILL: begin
        if (w_strobe && w_fill_ok) begin
          w_pop   = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_strobe) begin
          if (w_empty) begin
            unf     = 1'b1;
            state_d = ST_FILL;
          end else begin
            w_pop   = 1'b1;
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
    if (rst) begin
      w_pop = 1'b0;
      unf   = 1'b0;
    end
    w_push = val_in && !rst && (!w_full || w_pop);
    ovf    = val_in && !rst && w_full && !w_pop;
  end

  // Output register next values: a new code only on a pop, otherwise hold.
  always_comb begin
    o_dac_d  = o_dac_q;
    dac_wr_d = w_pop;
    if (w_pop) begin
      o_dac_d = w_code;
    end
  end

  // State, counter and output registers; reset parks the DAC at midscale of
  // whichever format is selected at that time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FILL;
      cnt_q    <= '0;
      o_dac_q  <= fmt_twos ? '0 : w_midscale;
      dac_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      o_dac_q  <= o_dac_d;
      dac_wr_q <= dac_wr_d;
    end
  end

  assign o_dac  = o_dac_q;
  assign dac_wr = dac_wr_q;
  assign level  = w_level;

`ifdef DAC_OUT_STATS_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;
  logic [15:0] unf_cnt_q, unf_cnt_d;

  // Saturating bump; a clear in the same cycle as an event leaves 1.
  function automatic logic [15:0] stat_next(input logic [15:0] cur,
                                            input logic        clr,
                                            input logic        evt);
    logic [15:0] base;
    base = clr ? 16'h0000 : cur;
    if (evt && (base != 16'hFFFF)) begin
      stat_next = base + 16'h0001;
    end else begin
      stat_next = base;
    end
  endfunction

  // Event counter next values.
  always_comb begin
    ovf_cnt_d = stat_next(ovf_cnt_q, stats_clr, ovf);
    unf_cnt_d = stat_next(unf_cnt_q, stats_clr, unf);
  end

  // Event counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      unf_cnt_q <= unf_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
  assign unf_cnt = unf_cnt_q;
`endif

endmodule
`default_nettype wire
